// File: rtl/twofish_pkg.sv
// Shared Twofish definitions: q-permutation nibble tables, FSM state
// encoding and per-layer q-select patterns for the h-function S-boxes.
package twofish_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L0   = 3'd1,
        ST_L1   = 3'd2,
        ST_L2   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Bit j selects the q for byte lane j: 0 = q0, 1 = q1.
    localparam logic [3:0] SEL_L0 = 4'b1010;
    localparam logic [3:0] SEL_L1 = 4'b1100;
    localparam logic [3:0] SEL_L2 = 4'b0101;

    localparam logic [3:0] Q0_T0 [16] = '{
        4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
        4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
    localparam logic [3:0] Q0_T1 [16] = '{
        4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
        4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
    localparam logic [3:0] Q0_T2 [16] = '{
        4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
        4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
    localparam logic [3:0] Q0_T3 [16] = '{
        4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
        4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};

    localparam logic [3:0] Q1_T0 [16] = '{
        4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE,
        4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5};
    localparam logic [3:0] Q1_T1 [16] = '{
        4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7,
        4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8};
    localparam logic [3:0] Q1_T2 [16] = '{
        4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA,
        4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF};
    localparam logic [3:0] Q1_T3 [16] = '{
        4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE,
        4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA};

    function automatic logic [3:0] ror4(input logic [3:0] v);
        return {v[0], v[3:1]};
    endfunction

endpackage

// File: rtl/twofish_q_perm.sv
// Combinational Twofish q0/q1 byte permutation built from the
// nibble network; sel=0 gives q0, sel=1 gives q1.
module twofish_q_perm
    import twofish_pkg::*;
(
    input  logic       sel,
    input  logic [7:0] d,
    output logic [7:0] q
);

    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;

    always_comb begin
        a0 = d[7:4];
        b0 = d[3:0];
        a1 = a0 ^ b0;
        b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
        a2 = sel ? Q1_T0[a1] : Q0_T0[a1];
        b2 = sel ? Q1_T1[b1] : Q0_T1[b1];
        a3 = a2 ^ b2;
        b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
        a4 = sel ? Q1_T2[a3] : Q0_T2[a3];
        b4 = sel ? Q1_T3[b3] : Q0_T3[b3];
    end

    assign q = {b4, a4};

endmodule

// File: rtl/twofish_h_sbox.sv
// Iterative k=2 Twofish h-function S-box stage: one q layer per cycle,
// result held in DONE until the downstream MDS block takes it.
module twofish_h_sbox
    import twofish_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_l0,
    input  logic [31:0] in_l1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y
);

    state_t      state;
    logic [31:0] work;
    logic [31:0] key0;
    logic [31:0] key1;
    logic [31:0] lane;
    logic [3:0]  sel;
    logic        accept;

    assign in_ready = ~rst & ((state == ST_IDLE) |
                              ((state == ST_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_DONE);
    assign out_y     = work;

    always_comb begin
        sel = 4'b0000;
        unique case (state)
            ST_L0:   sel = SEL_L0;
            ST_L1:   sel = SEL_L1;
            ST_L2:   sel = SEL_L2;
            default: sel = 4'b0000;
        endcase
    end

    for (genvar j = 0; j < 4; j++) begin : g_lane
        twofish_q_perm u_q (
            .sel (sel[j]),
            .d   (work[8*j +: 8]),
            .q   (lane[8*j +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            work  <= 32'h0;
            key0  <= 32'h0;
            key1  <= 32'h0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        work  <= in_x;
                        key0  <= in_l0;
                        key1  <= in_l1;
                        state <= ST_L0;
                    end
                end
                ST_L0: begin
                    work  <= lane ^ key1;
                    state <= ST_L1;
                end
                ST_L1: begin
                    work  <= lane ^ key0;
                    state <= ST_L2;
                end
                ST_L2: begin
                    work  <= lane;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    // accept implies out_ready, so the result is consumed here
                    if (accept) begin
                        work  <= in_x;
                        key0  <= in_l0;
                        key1  <= in_l1;
                        state <= ST_L0;
                    end else if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/twofish_h_sbox.md
# twofish_h_sbox

Iterative key-dependent S-box stage of the Twofish h function for 128-bit keys (k = 2). Takes a 32-bit input word and two 32-bit key words (l0, l1), applies the three q-permutation layers with interleaved key XORs, one layer per cycle, and presents the 32-bit result to the downstream MDS multiply. It sits directly upstream of the MDS block in both the g-function (round) path and the key-schedule h path.

## Interface
- No parameters; key length is fixed at 128 bits.
- Clock: one clock. Reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_x`, `in_l0` and `in_l1` are valid.
- `in_ready` out 1: block can accept a new input.
- `in_x` in 32: input word; byte j is `in_x[8j+7:8j]`.
- `in_l0` in 32: outer key word (XORed after layer 1).
- `in_l1` in 32: inner key word (XORed after layer 0).
- `out_valid` out 1: `out_y` holds a completed result.
- `out_ready` in 1: downstream accepts `out_y`.
- `out_y` out 32: S-box output in the same byte order; feeds the MDS input directly.

## Operation
- Function, per byte j (x = input byte, y = output byte):
  - y0 = q1[q0[q0[x0]^l1_0]^l0_0]
  - y1 = q0[q0[q1[x1]^l1_1]^l0_1]
  - y2 = q1[q1[q0[x2]^l1_2]^l0_2]
  - y3 = q0[q1[q1[x3]^l1_3]^l0_3]
- Layer q-selects for bytes 0..3:
  - Layer 0 (innermost): q0,q1,q0,q1.
  - Layer 1: q0,q0,q1,q1.
  - Layer 2: q1,q0,q1,q0.
- q-permutation follows the standard Twofish nibble network: a0/b0 split, t0..t3 4-bit tables, ROR4 by 1, and the 8*a mod 16 term; output is 16*b4 + a4.
- All arithmetic is 8-bit XOR and table lookup. There is no carry arithmetic anywhere in the block.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid` (handshake), latch x, l0 and l1 into working registers, go to L0.
  - L0: work <= layer0(work) ^ l1; go to L1.
  - L1: work <= layer1(work) ^ l0; go to L2.
  - L2: work <= layer2(work); go to DONE.
  - DONE: `out_valid`=1 and `out_y`=work.
    - If `out_ready` and `in_valid`: the output handshake completes and the new input is latched in the same cycle; go to L0.
    - If `out_ready` only: go to IDLE.
    - Otherwise stay in DONE.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready), and is forced to 0 while `rst` is high.
- While `out_valid` is high, `out_y` is stable until the handshake completes.
- Inputs are sampled only on the input handshake. Later changes to `in_*` have no effect on the result in flight.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `out_y`=32'h0, and the key registers are 0. `in_ready` reads 1 from the first cycle after `rst` is released.
- Latency: accept at edge T gives `out_valid`=1 after edge T+3.
- Throughput: one result per 4 cycles with back-to-back handshakes through DONE. It is one per 5 cycles if the block returns through IDLE.
- Backpressure: DONE holds for any number of cycles. Nothing is dropped or overwritten.
- Reset mid-operation (in L0, L1, L2 or DONE): the in-flight result is discarded, the block returns to IDLE next cycle, and `out_valid` deasserts on that edge.
- `in_valid` asserted in L0 through L2 is ignored, because `in_ready`=0.

## Structure
- `twofish_pkg` (shared package):
  - t0..t3 tables for q0 and q1 as constant arrays of 16×4-bit.
  - Enum for the FSM state.
  - Per-layer q-select constants (4-bit vector per layer).
- Sub-module `twofish_q_perm`: combinational, 8-bit in and 8-bit out, with a `sel` input choosing q0 or q1. Instantiate it four times (one per byte lane). Each lane's `sel` is muxed from the layer-select constant indexed by the current state.
- The MDS stage consumes `out_y` unmodified. No byte swapping takes place between the two blocks.

## Test plan
- **q_perm unit:** x=8'h00 with sel=q0 -> 8'hA9; sel=q1 -> 8'h75. Sweep all 256 inputs for both selects and confirm each is a permutation (no duplicate outputs).
- **Single op, zero key:** x=32'h0, l0=l1=32'h0, `out_ready`=1.
  - `in_ready` drops for 3 cycles.
  - `out_valid` rises exactly 3 edges after accept.
  - `out_y` matches the golden C model of h for k=2.
- **Key sensitivity:** x=32'h03020100, l1=32'h0, l0 changed from 32'h0 to 32'h00000001.
  - Only byte 0 of `out_y` changes.
  - Both results match the golden model.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE.
  - `out_y` and `out_valid` stay stable.
  - `in_ready`=0 throughout.
  - Raising `out_ready` with `in_valid` high completes both handshakes in one cycle; the next result appears 3 edges later.
- **Back-to-back stream:** 100 random (x, l0, l1) triples with `in_valid` and `out_ready` held at 1.
  - One result every 4 cycles.
  - All results match the model and arrive in order.
- **Reset mid-op:** assert `rst` for 1 cycle while in L1.
  - Next cycle: IDLE, `out_valid`=0, `out_y`=0.
  - No stale result is emitted.
  - A following op completes correctly.
